// File: rtl/risc_v_32i_pkg.sv
// Shared RV32I register-file definitions used by the write-back path.
package risc_v_32i;

   localparam int REG_WIDTH = 5;
   localparam int REG_SIZE  = 32;
   localparam int REG_COUNT = 32;

   typedef enum logic [0:0] {
      WB_CLEAR = 1'b0,
      WB_RUN   = 1'b1
   } wb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: zeroes x1..x31 after reset, then
// round-robin arbitrates the single write port between ALU (A) and load (M).
import risc_v_32i::*;

module regfile_wb_arbiter #(
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   input  logic [REG_WIDTH-1:0]  a_addr,
   input  logic [REG_SIZE-1:0]   a_data,
   output logic                  a_ready,
   input  logic                  m_valid,
   input  logic [REG_WIDTH-1:0]  m_addr,
   input  logic [REG_SIZE-1:0]   m_data,
   output logic                  m_ready,
   output logic                  write_enable,
   output logic [REG_WIDTH-1:0]  write_addr,
   output logic [REG_SIZE-1:0]   write_data,
   output logic                  init_done
);

   localparam wb_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? WB_CLEAR : WB_RUN;

   wb_state_t            state;
   logic [REG_WIDTH-1:0] counter;
   logic                 ptr_m;
   logic                 live;
   logic                 a_fire;
   logic                 m_fire;

   // Readies are gated by init_done so they stay low through reset and the
   // first cycle, even when the clear sequence is skipped.
   assign live    = (state == WB_RUN) && init_done;
   assign a_ready = live && a_valid && (!m_valid || !ptr_m);
   assign m_ready = live && m_valid && (!a_valid || ptr_m);
   assign a_fire  = a_valid && a_ready;
   assign m_fire  = m_valid && m_ready;

   // The clear counter wraps from 31 to 0; the zero value marks the extra
   // edge on which init_done rises and the state moves to RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RESET_STATE;
         counter      <= {{(REG_WIDTH-1){1'b0}}, 1'b1};
         ptr_m        <= 1'b0;
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         init_done    <= 1'b0;
      end else begin
         case (state)
            WB_CLEAR: begin
               if (counter != '0) begin
                  write_enable <= 1'b1;
                  write_addr   <= counter;
                  write_data   <= '0;
                  counter      <= counter + 1'b1;
               end else begin
                  write_enable <= 1'b0;
                  state        <= WB_RUN;
                  init_done    <= 1'b1;
                  counter      <= {{(REG_WIDTH-1){1'b0}}, 1'b1};
               end
            end
            WB_RUN: begin
               init_done <= 1'b1;
               if (a_fire) begin
                  write_enable <= (a_addr != '0);
                  ptr_m        <= 1'b1;
                  if (a_addr != '0) begin
                     write_addr <= a_addr;
                     write_data <= a_data;
                  end
               end else if (m_fire) begin
                  write_enable <= (m_addr != '0);
                  ptr_m        <= 1'b0;
                  if (m_addr != '0) begin
                     write_addr <= m_addr;
                     write_data <= m_data;
                  end
               end else begin
                  write_enable <= 1'b0;
               end
            end
            default: begin
               state        <= RESET_STATE;
               write_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with clear enabled and disabled.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        a_valid, m_valid;
   logic [4:0]  a_addr, m_addr;
   logic [31:0] a_data, m_data;
   logic        a_ready, m_ready;
   logic        write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        init_done;

   logic        rst1_n;
   logic        a_valid1, m_valid1;
   logic [4:0]  a_addr1, m_addr1;
   logic [31:0] a_data1, m_data1;
   logic        a_ready1, m_ready1;
   logic        write_enable1;
   logic [4:0]  write_addr1;
   logic [31:0] write_data1;
   logic        init_done1;

   logic [31:0] rf [32];

   int vectors;
   int miscompares;

   regfile_wb_arbiter #(.CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
      .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .init_done(init_done)
   );

   regfile_wb_arbiter #(.CLEAR_ON_RESET(0)) dut_noclear (
      .clk(clk), .rst_n(rst1_n),
      .a_valid(a_valid1), .a_addr(a_addr1), .a_data(a_data1), .a_ready(a_ready1),
      .m_valid(m_valid1), .m_addr(m_addr1), .m_data(m_data1), .m_ready(m_ready1),
      .write_enable(write_enable1), .write_addr(write_addr1),
      .write_data(write_data1), .init_done(init_done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple register-file model that commits on the edge after the write port is driven.
   always @(posedge clk) begin
      if (write_enable) rf[write_addr] <= write_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md);
      a_valid = av; a_addr = aa; a_data = ad;
      m_valid = mv; m_addr = ma; m_data = md;
   endtask

   logic [4:0]  exp_addr [4];
   logic [31:0] exp_data [4];
   logic        exp_a    [4];
   logic [4:0]  qa_addr  [2];
   logic [31:0] qa_data  [2];
   logic [4:0]  qm_addr  [2];
   logic [31:0] qm_data  [2];

   initial begin
      int ai, mi;
      vectors = 0;
      miscompares = 0;
      rst_n  = 1'b0;
      rst1_n = 1'b0;
      applyStimulus(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
      a_valid1 = 1'b0; a_addr1 = 5'd0; a_data1 = 32'h0;
      m_valid1 = 1'b0; m_addr1 = 5'd0; m_data1 = 32'h0;

      #12;
      checkOutput("rst_we",    {31'd0, write_enable}, 32'd0);
      checkOutput("rst_addr",  {27'd0, write_addr},   32'd0);
      checkOutput("rst_data",  write_data,            32'd0);
      checkOutput("rst_init",  {31'd0, init_done},    32'd0);
      checkOutput("rst_ready", {30'd0, a_ready, m_ready}, 32'd0);

      // Clear sequence with both requesters already asking.
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 31; e++) begin
         @(posedge clk); #1;
         checkOutput("clr_we",    {31'd0, write_enable}, 32'd1);
         checkOutput("clr_addr",  {27'd0, write_addr},   e + 1);
         checkOutput("clr_data",  write_data,            32'd0);
         checkOutput("clr_init",  {31'd0, init_done},    32'd0);
         checkOutput("clr_ready", {30'd0, a_ready, m_ready}, 32'd0);
      end
      @(posedge clk); #1;
      checkOutput("clr_done_init", {31'd0, init_done},    32'd1);
      checkOutput("clr_done_we",   {31'd0, write_enable}, 32'd0);
      checkOutput("first_ready",   {30'd0, a_ready, m_ready}, 32'b10);
      checkOutput("rf_x1_clear",   rf[1],  32'd0);
      checkOutput("rf_x31_clear",  rf[31], 32'd0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("idle_ready", {30'd0, a_ready, m_ready}, 32'd0);

      // Single ALU write.
      applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("a_only_ready", {30'd0, a_ready, m_ready}, 32'b10);
      @(posedge clk); #1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("a_only_we",   {31'd0, write_enable}, 32'd1);
      checkOutput("a_only_addr", {27'd0, write_addr},   32'd5);
      checkOutput("a_only_data", write_data,            32'hDEAD_BEEF);
      @(posedge clk); #1;
      checkOutput("a_only_we_off", {31'd0, write_enable}, 32'd0);
      checkOutput("a_only_hold",   {27'd0, write_addr},   32'd5);
      checkOutput("rf_x5",         rf[5],                 32'hDEAD_BEEF);

      // Load to x0: accepted, no write, pointer returns to A.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_1234);
      #1;
      checkOutput("m_x0_ready", {30'd0, a_ready, m_ready}, 32'b01);
      @(posedge clk); #1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("m_x0_we", {31'd0, write_enable}, 32'd0);
      @(posedge clk); #1;
      checkOutput("rf_x0", rf[0], 32'd0);

      // Contention: both queues of two requests, grants must alternate A, M, A, M.
      qa_addr[0] = 5'd10; qa_data[0] = 32'hA0A0_0001;
      qa_addr[1] = 5'd11; qa_data[1] = 32'hA0A0_0002;
      qm_addr[0] = 5'd20; qm_data[0] = 32'hB0B0_0001;
      qm_addr[1] = 5'd21; qm_data[1] = 32'hB0B0_0002;
      exp_a[0] = 1'b1; exp_addr[0] = 5'd10; exp_data[0] = 32'hA0A0_0001;
      exp_a[1] = 1'b0; exp_addr[1] = 5'd20; exp_data[1] = 32'hB0B0_0001;
      exp_a[2] = 1'b1; exp_addr[2] = 5'd11; exp_data[2] = 32'hA0A0_0002;
      exp_a[3] = 1'b0; exp_addr[3] = 5'd21; exp_data[3] = 32'hB0B0_0002;
      ai = 0; mi = 0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(ai < 2, qa_addr[ai % 2], qa_data[ai % 2],
                       mi < 2, qm_addr[mi % 2], qm_data[mi % 2]);
         #1;
         checkOutput("rr_ready", {30'd0, a_ready, m_ready}, exp_a[k] ? 32'b10 : 32'b01);
         @(posedge clk); #1;
         if (exp_a[k]) ai++; else mi++;
         checkOutput("rr_we",   {31'd0, write_enable}, 32'd1);
         checkOutput("rr_addr", {27'd0, write_addr},   {27'd0, exp_addr[k]});
         checkOutput("rr_data", write_data,            exp_data[k]);
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Reset during RUN drops the in-flight write, then restart and abort at counter 10.
      rst_n = 1'b0;
      #1;
      checkOutput("run_rst_we",   {31'd0, write_enable}, 32'd0);
      checkOutput("run_rst_init", {31'd0, init_done},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 9; e++) begin
         @(posedge clk); #1;
         checkOutput("pre_abort_addr", {27'd0, write_addr}, e + 1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_we",   {31'd0, write_enable}, 32'd0);
      checkOutput("abort_addr", {27'd0, write_addr},   32'd0);
      checkOutput("abort_init", {31'd0, init_done},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 31; e++) begin
         @(posedge clk); #1;
         checkOutput("reclr_we",   {31'd0, write_enable}, 32'd1);
         checkOutput("reclr_addr", {27'd0, write_addr},   e + 1);
      end
      @(posedge clk); #1;
      checkOutput("reclr_init", {31'd0, init_done}, 32'd1);

      // No-clear instance: ALU request held across reset release.
      a_valid1 = 1'b1; a_addr1 = 5'd7; a_data1 = 32'h0000_55AA;
      #1;
      checkOutput("nc_rst_ready", {31'd0, a_ready1},  32'd0);
      checkOutput("nc_rst_init",  {31'd0, init_done1}, 32'd0);
      @(negedge clk);
      rst1_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("nc_init",  {31'd0, init_done1},    32'd1);
      checkOutput("nc_ready", {31'd0, a_ready1},      32'd1);
      checkOutput("nc_we0",   {31'd0, write_enable1}, 32'd0);
      @(posedge clk); #1;
      a_valid1 = 1'b0;
      checkOutput("nc_we1",   {31'd0, write_enable1}, 32'd1);
      checkOutput("nc_addr",  {27'd0, write_addr1},   32'd7);
      checkOutput("nc_data",  write_data1,            32'h0000_55AA);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the integer register file. After reset it sequences a clear of x1..x31 to zero, because the register array itself has no reset. It then shares the single register-file write port between two write-back requesters, ALU (port A) and load unit (port M), using round-robin arbitration with a valid/ready handshake. It sits between the execute/memory stages and the register file's `write_enable`/`write_addr`/`write_data` inputs.

## Interface
Parameters:
- `CLEAR_ON_RESET`, default 1: 1 = run the zeroing sequence after reset; 0 = go straight to arbitration.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `a_valid`  in  1  ALU write-back request.
- `a_addr`  in  REG_WIDTH  ALU destination register.
- `a_data`  in  REG_SIZE  ALU result.
- `a_ready`  out  1  ALU request accepted this cycle.
- `m_valid`  in  1  load write-back request.
- `m_addr`  in  REG_WIDTH  load destination register.
- `m_data`  in  REG_SIZE  load data.
- `m_ready`  out  1  load request accepted this cycle.
- `write_enable`  out  1  to register file, registered.
- `write_addr`  out  REG_WIDTH  to register file, registered.
- `write_data`  out  REG_SIZE  to register file, registered.
- `init_done`  out  1  high once the clear has finished; stays high until the next reset.

## Operation
- State machine: states CLEAR and RUN.
  - Reset entry: CLEAR if `CLEAR_ON_RESET`=1, else RUN.
- CLEAR:
  - 5-bit counter starts at 1.
  - Each cycle drive `write_enable`=1, `write_addr`=counter, `write_data`=0, then increment the counter.
  - Counter==31 issued → go to RUN.
  - `a_ready` and `m_ready` are held at 0 throughout.
  - x0 is never written.
- RUN, arbitration:
  - Ready signals are combinational from state, valids and the round-robin pointer. No backpressure ever comes from the register file.
  - Only one requester valid → it gets ready=1.
  - Both valid → the port named by the pointer wins. The loser sees ready=0 and must hold valid, addr and data stable until it gets ready.
  - Pointer reset value is A. On every accepted transfer the pointer moves to the other port.
  - Neither valid → both readies are 0 (idle) and the pointer does not move.
- RUN, write-back:
  - An accepted transfer (valid && ready) is registered onto the write port at the next edge: `write_enable`=1, with that request's addr and data.
  - No transfer → `write_enable`=0; `write_addr`/`write_data` hold their last values.
  - A request with addr 0 is accepted normally, sets `write_enable`=0, and still advances the pointer.
- At most one write per cycle, so no write-write conflict can reach the register file.

## Timing
- Reset values, asserted asynchronously on `rst_n` low: `write_enable`=0, `write_addr`=0, `write_data`=0, `init_done`=0, `a_ready`=0, `m_ready`=0, pointer=A, counter=1.
- Clear sequence: edge 0 is the first rising edge with `rst_n` high.
  - Edges 0..30 register writes to addr 1..31.
  - The register file commits those writes at edges 1..31.
  - At edge 31, `init_done` rises and the state becomes RUN. Readies may assert in the cycle after edge 31.
- With `CLEAR_ON_RESET`=0: `init_done`=1 and readies are live from edge 0.
- Accept latency: a handshake in cycle N puts the register-file write on edge N+1 (outputs valid after edge N); the write commits at edge N+2.
- Throughput: 1 write/cycle. Under continuous contention the two ports alternate A, M, A, M.
- Reset mid-CLEAR or mid-RUN: the in-flight registered write is dropped (`write_enable` forced to 0). The sequence restarts from counter=1 after release.

## Structure
- Use REG_WIDTH and REG_SIZE from package `risc_v_32i`.
- Add to `risc_v_32i`:
  - typedef `wb_state_t` enum {WB_CLEAR, WB_RUN}.
  - localparam `REG_COUNT`=32.
- Single module, no sub-module. The round-robin pick is about ten lines and stays inline.

## Test plan
- Reset release with `CLEAR_ON_RESET`=1: expect 31 consecutive writes, addr 1..31, data 0; `init_done`=1 after edge 31; readies 0 throughout CLEAR.
- A only, `a_addr`=5, `a_data`=0xDEADBEEF, one cycle: `a_ready`=1 the same cycle; next cycle `write_enable`=1, addr 5, data 0xDEADBEEF; register-file read of x5 afterwards returns 0xDEADBEEF.
- A and M both valid for 4 cycles, each with distinct addr/data held until accepted: grants go A, M, A, M; the loser's ready=0 in its stall cycle; 4 correct writes in order.
- M with `m_addr`=0, `m_data`=0x1234: `m_ready`=1, `write_enable` stays 0, pointer advances; x0 still reads 0.
- Assert `rst_n` low at CLEAR counter=10, then release: outputs go to reset values immediately; the clear restarts at addr 1 and completes 31 cycles later.
- `CLEAR_ON_RESET`=0, `a_valid` high during reset release: `init_done`=1 and `a_ready`=1 in the first cycle; the write appears after edge 1.
